// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaled pixel strobe, h/v counters,
// registered coordinates, sync, active-video flag, line/frame strobes and frame count.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 1,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           restart,
    output logic           px_en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           active,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start,
    output logic [15:0]    frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int P_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [P_W-1:0] PRE_LAST = P_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic           HS_ACT   = (H_POL != 0);
    localparam logic           VS_ACT   = (V_POL != 0);

    logic [P_W-1:0] pre_cnt;
    logic [X_W-1:0] h_cnt;
    logic [Y_W-1:0] v_cnt;
    logic           tick;
    logic           h_wrap;
    logic           v_wrap;
    logic           pix_active;
    logic           pix_hs;
    logic           pix_vs;

    // h_cnt/v_cnt always hold the pixel the next tick will present; the
    // compares are done 32 bits wide so an end bound equal to 2^X_W still works.
    always_comb begin
        tick       = enable && !restart && (pre_cnt == PRE_LAST);
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        pix_active = (32'(h_cnt) < 32'(H_ACTIVE)) && (32'(v_cnt) < 32'(V_ACTIVE));
        pix_hs     = (32'(h_cnt) >= 32'(HS_START)) && (32'(h_cnt) < 32'(HS_END));
        pix_vs     = (32'(v_cnt) >= 32'(VS_START)) && (32'(v_cnt) < 32'(VS_END));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (restart) begin
            pre_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            h_cnt   <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
        end else if (enable) begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Strobes follow tick, so enable=0 or restart forces them low; the
    // remaining outputs only load on a tick and otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            px_en       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            frame_count <= '0;
        end else begin
            px_en       <= tick;
            line_start  <= tick && (h_cnt == '0);
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                x      <= h_cnt;
                y      <= v_cnt;
                active <= pix_active;
                hsync  <= pix_hs ? HS_ACT : ~HS_ACT;
                vsync  <= pix_vs ? VS_ACT : ~VS_ACT;
                if (h_wrap && v_wrap) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

endmodule
